// File: rtl/decode_scan_ctrl.sv
// Scan sequencer driving decoder_3_8 E/In: walks enabled channels with a dwell and a one-cycle blank.
// Optional pass counter output enabled by `define SCAN_PASS_CNT_EN.
module decode_scan_ctrl #(
  parameter int DWELL_W = 8,
  parameter int NUM_CH  = 8
) (
  input  logic               clka,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               cont,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [NUM_CH-1:0]  ch_mask,
  output logic               E,
  output logic [2:0]         In,
  output logic               busy,
  output logic               ch_strobe,
`ifdef SCAN_PASS_CNT_EN
  output logic [7:0]         pass_cnt,
`endif
  output logic               done
);

  typedef enum logic [1:0] {S_IDLE, S_DWELL, S_BLANK} state_t;

  state_t             r_state, w_nxt_state;
  logic               r_e, w_nxt_e;
  logic [2:0]         r_in, w_nxt_in;
  logic               r_busy, w_nxt_busy;
  logic               r_strobe, w_nxt_strobe;
  logic               r_done, w_nxt_done;
  logic [DWELL_W-1:0] r_cnt, w_nxt_cnt;
  logic [NUM_CH-1:0]  r_mask, w_nxt_mask;
  logic [DWELL_W-1:0] r_dwell, w_nxt_dwell;
  logic               r_cont, w_nxt_cont;

  logic [DWELL_W-1:0] w_dw_in;
  logic [NUM_CH-1:0]  w_above;
  logic               w_start_acc;

  function automatic logic [2:0] lowest(input logic [NUM_CH-1:0] m);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = NUM_CH-1; i >= 0; i--)
      if (m[i]) idx = i[2:0];
    return idx;
  endfunction

  assign w_dw_in     = (dwell == '0) ? DWELL_W'(1) : dwell;
  // Latched channels strictly above the one currently selected
  assign w_above     = r_mask & (8'hFE << r_in);
  assign w_start_acc = (r_state == S_IDLE) && start && !stop && (|ch_mask);

  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_e      = r_e;
    w_nxt_in     = r_in;
    w_nxt_busy   = r_busy;
    w_nxt_strobe = 1'b0;
    w_nxt_done   = 1'b0;
    w_nxt_cnt    = r_cnt;
    w_nxt_mask   = r_mask;
    w_nxt_dwell  = r_dwell;
    w_nxt_cont   = r_cont;
    case (r_state)
      S_IDLE: begin
        w_nxt_e    = 1'b0;
        w_nxt_busy = 1'b0;
        if (w_start_acc) begin
          w_nxt_mask   = ch_mask;
          w_nxt_dwell  = w_dw_in;
          w_nxt_cont   = cont;
          w_nxt_in     = lowest(ch_mask);
          w_nxt_cnt    = w_dw_in;
          w_nxt_e      = 1'b1;
          w_nxt_busy   = 1'b1;
          w_nxt_strobe = 1'b1;
          w_nxt_state  = S_DWELL;
        end
      end
      S_DWELL: begin
        if (stop) begin
          w_nxt_state = S_IDLE;
          w_nxt_e     = 1'b0;
          w_nxt_busy  = 1'b0;
        end else if (r_cnt <= DWELL_W'(1)) begin
          w_nxt_state = S_BLANK;
          w_nxt_e     = 1'b0;
        end else begin
          w_nxt_cnt = r_cnt - DWELL_W'(1);
        end
      end
      S_BLANK: begin
        if (stop) begin
          w_nxt_state = S_IDLE;
          w_nxt_busy  = 1'b0;
        end else if (|w_above) begin
          w_nxt_in     = lowest(w_above);
          w_nxt_cnt    = r_dwell;
          w_nxt_e      = 1'b1;
          w_nxt_strobe = 1'b1;
          w_nxt_state  = S_DWELL;
        end else if (r_cont) begin
          // Wrap: pick up fresh mask/dwell; cont stays as latched at start
          w_nxt_mask  = ch_mask;
          w_nxt_dwell = w_dw_in;
          if (|ch_mask) begin
            w_nxt_in     = lowest(ch_mask);
            w_nxt_cnt    = w_dw_in;
            w_nxt_e      = 1'b1;
            w_nxt_strobe = 1'b1;
            w_nxt_state  = S_DWELL;
          end else begin
            w_nxt_busy  = 1'b0;
            w_nxt_state = S_IDLE;
          end
        end else begin
          w_nxt_busy  = 1'b0;
          w_nxt_done  = 1'b1;
          w_nxt_state = S_IDLE;
        end
      end
      default: begin
        w_nxt_state = S_IDLE;
        w_nxt_e     = 1'b0;
        w_nxt_busy  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_e      <= 1'b0;
      r_in     <= 3'd0;
      r_busy   <= 1'b0;
      r_strobe <= 1'b0;
      r_done   <= 1'b0;
      r_cnt    <= '0;
      r_mask   <= '0;
      r_dwell  <= '0;
      r_cont   <= 1'b0;
    end else begin
      r_state  <= w_nxt_state;
      r_e      <= w_nxt_e;
      r_in     <= w_nxt_in;
      r_busy   <= w_nxt_busy;
      r_strobe <= w_nxt_strobe;
      r_done   <= w_nxt_done;
      r_cnt    <= w_nxt_cnt;
      r_mask   <= w_nxt_mask;
      r_dwell  <= w_nxt_dwell;
      r_cont   <= w_nxt_cont;
    end
  end

`ifdef SCAN_PASS_CNT_EN
  logic [7:0] r_pass_cnt;
  logic       w_pass_inc;
  // A pass ends in BLANK with no higher channel left (done or wrap)
  assign w_pass_inc = (r_state == S_BLANK) && !stop && !(|w_above);

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n)          r_pass_cnt <= 8'd0;
    else if (w_start_acc) r_pass_cnt <= 8'd0;
    else if (w_pass_inc)  r_pass_cnt <= r_pass_cnt + 8'd1;
  end
  assign pass_cnt = r_pass_cnt;
`endif

  assign E         = r_e;
  assign In        = r_in;
  assign busy      = r_busy;
  assign ch_strobe = r_strobe;
  assign done      = r_done;

endmodule
